// File: rtl/pipelined_divider_stall.sv
// Purpose     : pipelined signed restoring divider with optional round-half-away-from-zero,
//               positive saturation, divide-by-zero reporting and a sideband tag.
// Latency     : DIVIDEND_WIDTH+2 advancing cycles; one beat per advancing cycle.
// Backpressure: one global advance (!output_valid || output_ready) stalls every stage;
//               input_ready equals advance.
// Ports:
//   clock, reset_n              rising-edge clock, synchronous active-low reset
//   input_valid/input_ready     operand handshake; input_tag, input_round, dividend, divisor
//   output_valid/output_ready   result handshake; output_tag, quotient, remainder,
//                               div_by_zero, overflow
module pipelined_divider_stall #(
  parameter int DIVIDEND_WIDTH = 12,
  parameter int DIVISOR_WIDTH  = 6,
  parameter int TAG_WIDTH      = 6,
  parameter int DIVISOR_SIGNED = 0
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      input_valid,
  output logic                      input_ready,
  input  logic [TAG_WIDTH-1:0]      input_tag,
  input  logic                      input_round,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      output_valid,
  input  logic                      output_ready,
  output logic [TAG_WIDTH-1:0]      output_tag,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVIDEND_WIDTH-1:0] remainder,
  output logic                      div_by_zero,
  output logic                      overflow
);

  localparam int DW = DIVIDEND_WIDTH;
  localparam int VW = DIVISOR_WIDTH;
  localparam logic [DW-1:0] Q_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] Q_MIN = {1'b1, {(DW-1){1'b0}}};

  // Per-beat sideband that rides alongside the remainder/quotient pair.
  typedef struct packed {
    logic [TAG_WIDTH-1:0] tag;
    logic                 q_neg;     // quotient sign
    logic                 r_neg;     // remainder sign (= dividend sign)
    logic                 rnd;
    logic                 dvs_zero;
    logic [VW-1:0]        dvs_mag;
    logic [DW-1:0]        dvd;       // original dividend, returned on divide-by-zero
  } meta_t;

  logic advance;
  assign advance     = !output_valid || output_ready;
  assign input_ready = advance;

  // Operand magnitudes. The DW-bit unsigned magnitude holds 2^(DW-1) exactly,
  // so the most-negative dividend (and most-negative signed divisor) loses nothing.
  logic          dvd_neg;
  logic          dvs_neg;
  logic [DW-1:0] dvd_mag;
  logic [VW-1:0] dvs_mag;
  assign dvd_neg = dividend[DW-1];
  assign dvs_neg = (DIVISOR_SIGNED != 0) && divisor[VW-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor : divisor;

  // Index 0 is the input register, 1..DW are the restoring steps.
  logic          stg_vld  [0:DW];
  meta_t         stg_meta [0:DW];
  logic [DW-1:0] stg_quo  [0:DW];
  logic [VW-1:0] stg_rem  [0:DW];
  logic [DW-1:0] nxt_quo  [1:DW];
  logic [VW-1:0] nxt_rem  [1:DW];

  // One restoring step: shift {rem,quo} left, try subtracting the divisor
  // from the upper VW+1 bits; keep the difference and set the quotient LSB
  // only when it does not borrow. The partial remainder stays below the
  // divisor, so VW bits suffice between steps.
  for (genvar g = 1; g <= DW; g++) begin : g_step
    logic [VW:0] shifted;
    logic [VW:0] trial;
    assign shifted    = {stg_rem[g-1], stg_quo[g-1][DW-1]};
    assign trial      = shifted - {1'b0, stg_meta[g-1].dvs_mag};
    assign nxt_rem[g] = trial[VW] ? shifted[VW-1:0] : trial[VW-1:0];
    assign nxt_quo[g] = {stg_quo[g-1][DW-2:0], ~trial[VW]};
  end

  // Result formatting from the last step.
  meta_t         out_meta;
  logic [VW:0]   rem_x2;
  logic          round_up;
  logic [DW:0]   q_mag;
  logic [DW-1:0] rem_ext;
  logic [DW-1:0] res_quo;
  logic [DW-1:0] res_rem;
  logic          res_dbz;
  logic          res_ovf;

  assign out_meta = stg_meta[DW];
  assign rem_x2   = {stg_rem[DW], 1'b0};
  assign round_up = out_meta.rnd && (rem_x2 >= {1'b0, out_meta.dvs_mag});
  // One extra bit so 2^(DW-1) (e.g. -2048/-1) is seen as too large for a positive result.
  assign q_mag    = {1'b0, stg_quo[DW]} + {{DW{1'b0}}, round_up};
  assign rem_ext  = DW'(stg_rem[DW]);

  always_comb begin
    res_quo = '0;
    res_rem = out_meta.r_neg ? -rem_ext : rem_ext;
    res_dbz = 1'b0;
    res_ovf = 1'b0;
    if (out_meta.dvs_zero) begin
      res_dbz = 1'b1;
      res_rem = out_meta.dvd;
      res_quo = out_meta.dvd[DW-1] ? Q_MIN : Q_MAX;
    end else if (!out_meta.q_neg && (q_mag > {1'b0, Q_MAX})) begin
      res_quo = Q_MAX;
      res_ovf = 1'b1;
    end else begin
      // Negative magnitudes never exceed 2^(DW-1): that needs a divisor of 1,
      // which leaves no remainder to round up.
      res_quo = out_meta.q_neg ? -q_mag[DW-1:0] : q_mag[DW-1:0];
    end
  end

  // Valid bits and outputs: reset, and held whenever the pipe is stalled.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i <= DW; i++) stg_vld[i] <= 1'b0;
      output_valid <= 1'b0;
      output_tag   <= '0;
      quotient     <= '0;
      remainder    <= '0;
      div_by_zero  <= 1'b0;
      overflow     <= 1'b0;
    end else if (advance) begin
      stg_vld[0] <= input_valid;
      for (int i = 1; i <= DW; i++) stg_vld[i] <= stg_vld[i-1];
      output_valid <= stg_vld[DW];
      output_tag   <= out_meta.tag;
      quotient     <= res_quo;
      remainder    <= res_rem;
      div_by_zero  <= res_dbz;
      overflow     <= res_ovf;
    end
  end

  // Datapath registers: no reset; bubbles carry don't-care data.
  always_ff @(posedge clock) begin
    if (advance) begin
      stg_meta[0].tag      <= input_tag;
      stg_meta[0].q_neg    <= dvd_neg ^ dvs_neg;
      stg_meta[0].r_neg    <= dvd_neg;
      stg_meta[0].rnd      <= input_round;
      stg_meta[0].dvs_zero <= (divisor == '0);
      stg_meta[0].dvs_mag  <= dvs_mag;
      stg_meta[0].dvd      <= dividend;
      stg_quo[0]           <= dvd_mag;
      stg_rem[0]           <= '0;
      for (int i = 1; i <= DW; i++) begin
        stg_meta[i] <= stg_meta[i-1];
        stg_quo[i]  <= nxt_quo[i];
        stg_rem[i]  <= nxt_rem[i];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_divider_stall.sv
// Purpose     : scoreboard bench for pipelined_divider_stall, unsigned- and signed-divisor builds.
// Latency     : expects results DIVIDEND_WIDTH+2 advancing cycles after acceptance.
// Backpressure: output_ready is held high or randomised; stalls are checked for output stability.
module tb_pipelined_divider_stall;

  localparam int DW   = 12;
  localparam int VW   = 6;
  localparam int TW   = 6;
  localparam int QMAX = 2**(DW-1) - 1;
  localparam int QMIN = -(2**(DW-1));

  logic          clock        = 1'b0;
  logic          reset_n      = 1'b0;
  logic          input_valid  = 1'b0;
  logic          input_round  = 1'b0;
  logic          output_ready = 1'b1;
  logic [TW-1:0] input_tag    = '0;
  logic [DW-1:0] dividend     = '0;
  logic [VW-1:0] divisor      = '0;

  logic          o_rdy [2];
  logic          o_vld [2];
  logic [TW-1:0] o_tag [2];
  logic [DW-1:0] o_quo [2];
  logic [DW-1:0] o_rem [2];
  logic          o_dbz [2];
  logic          o_ovf [2];

  int checks   = 0;
  int failures = 0;
  bit rand_rdy = 1'b0;
  int tag_ctr  = 0;

  typedef struct {
    int tag;
    int q;
    int r;
    int dbz;
    int ovf;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  always #5 clock = ~clock;

  pipelined_divider_stall #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW), .TAG_WIDTH(TW),
                            .DIVISOR_SIGNED(0)) dut_u (
    .clock(clock), .reset_n(reset_n),
    .input_valid(input_valid), .input_ready(o_rdy[0]), .input_tag(input_tag),
    .input_round(input_round), .dividend(dividend), .divisor(divisor),
    .output_valid(o_vld[0]), .output_ready(output_ready), .output_tag(o_tag[0]),
    .quotient(o_quo[0]), .remainder(o_rem[0]), .div_by_zero(o_dbz[0]), .overflow(o_ovf[0])
  );

  pipelined_divider_stall #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW), .TAG_WIDTH(TW),
                            .DIVISOR_SIGNED(1)) dut_s (
    .clock(clock), .reset_n(reset_n),
    .input_valid(input_valid), .input_ready(o_rdy[1]), .input_tag(input_tag),
    .input_round(input_round), .dividend(dividend), .divisor(divisor),
    .output_valid(o_vld[1]), .output_ready(output_ready), .output_tag(o_tag[1]),
    .quotient(o_quo[1]), .remainder(o_rem[1]), .div_by_zero(o_dbz[1]), .overflow(o_ovf[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division on the signed operand values.
  function automatic exp_t model(input int tag, input int a, input int b, input bit rnd);
    exp_t e;
    int am, bm, qm, rm;
    e.tag = tag; e.dbz = 0; e.ovf = 0;
    if (b == 0) begin
      e.dbz = 1;
      e.q   = (a >= 0) ? QMAX : QMIN;
      e.r   = a;
    end else begin
      am = (a < 0) ? -a : a;
      bm = (b < 0) ? -b : b;
      qm = am / bm;
      rm = am - qm * bm;
      if (rnd && (2 * rm >= bm)) qm++;
      e.q = ((a < 0) != (b < 0)) ? -qm : qm;
      if (e.q > QMAX) begin
        e.q   = QMAX;
        e.ovf = 1;
      end
      e.r = (a < 0) ? -rm : rm;
    end
    return e;
  endfunction

  // Issue side: record expectations for both builds on every accepted beat.
  always @(negedge clock) begin
    if (reset_n && input_valid && o_rdy[0]) begin
      sb0.push_back(model(int'(input_tag), int'($signed(dividend)), int'(divisor), input_round));
      sb1.push_back(model(int'(input_tag), int'($signed(dividend)), int'($signed(divisor)),
                          input_round));
    end
  end

  task automatic check_pop(input int d);
    exp_t e;
    bit have;
    have = 1'b0;
    if (d == 0) begin
      if (sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
    end else begin
      if (sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
    end
    if (!have) begin
      checks++;
      failures++;
      $display("FAIL unexpected_output dut%0d tag=%0d expected no beat", d, o_tag[d]);
    end else begin
      chk($sformatf("tag dut%0d", d), int'(o_tag[d]), e.tag);
      chk($sformatf("quotient dut%0d tag%0d", d, e.tag), int'($signed(o_quo[d])), e.q);
      chk($sformatf("remainder dut%0d tag%0d", d, e.tag), int'($signed(o_rem[d])), e.r);
      chk($sformatf("div_by_zero dut%0d tag%0d", d, e.tag), int'(o_dbz[d]), e.dbz);
      chk($sformatf("overflow dut%0d tag%0d", d, e.tag), int'(o_ovf[d]), e.ovf);
    end
  endtask

  // Output side: handshake rule, stall stability, and scoreboard pops.
  logic        stall_prev [2];
  logic [23:0] held_a     [2];
  logic [8:0]  held_b     [2];

  always @(negedge clock) begin
    if (!reset_n) begin
      for (int d = 0; d < 2; d++) stall_prev[d] <= 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("input_ready dut%0d", d), int'(o_rdy[d]), int'(!o_vld[d] || output_ready));
        if (stall_prev[d]) begin
          chk($sformatf("stall_data dut%0d", d), int'({o_quo[d], o_rem[d]}), int'(held_a[d]));
          chk($sformatf("stall_ctrl dut%0d", d), int'({o_vld[d], o_tag[d], o_dbz[d], o_ovf[d]}),
              int'(held_b[d]));
        end
        if (o_vld[d] && output_ready) check_pop(d);
        stall_prev[d] <= o_vld[d] && !output_ready;
        held_a[d]     <= {o_quo[d], o_rem[d]};
        held_b[d]     <= {o_vld[d], o_tag[d], o_dbz[d], o_ovf[d]};
      end
    end
  end

  initial forever begin
    @(posedge clock);
    #1;
    if (rand_rdy) output_ready = 1'($urandom_range(0, 1));
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [TW-1:0] t, input logic [DW-1:0] a, input logic [VW-1:0] b,
                      input logic r);
    bit acc;
    int n;
    input_tag = t; dividend = a; divisor = b; input_round = r; input_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 500) begin
      @(negedge clock);
      acc = o_rdy[0];
      @(posedge clock);
      #1;
      n++;
    end
    input_valid = 1'b0;
    if (!acc) chk("send_accepted", int'(acc), 1);
  endtask

  task automatic rand_beat(input logic [TW-1:0] t);
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    int k;
    a = DW'($urandom);
    if ($urandom_range(0, 7) == 0) a = {1'b1, {(DW-1){1'b0}}};
    k = int'($urandom_range(0, 9));
    if (k == 0)      b = '0;
    else if (k == 1) b = '1;
    else if (k == 2) b = VW'(1);
    else             b = VW'($urandom);
    send(t, a, b, 1'($urandom_range(0, 1)));
  endtask

  task automatic directed(input int d, input int a, input int b, input bit r,
                          input int eq, input int er, input int edbz, input int eovf);
    int lat;
    bit got;
    rand_rdy     = 1'b0;
    output_ready = 1'b1;
    send(TW'(tag_ctr), DW'(a), VW'(b), r);
    tag_ctr++;
    lat = 1;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clock);
      if (o_vld[d]) got = 1'b1;
      else begin
        @(posedge clock);
        lat++;
      end
    end
    chk($sformatf("latency %0d/%0d", a, b), lat, DW + 2);
    chk($sformatf("dir_quotient %0d/%0d r%0d", a, b, r), int'($signed(o_quo[d])), eq);
    chk($sformatf("dir_remainder %0d/%0d", a, b), int'($signed(o_rem[d])), er);
    chk($sformatf("dir_div_by_zero %0d/%0d", a, b), int'(o_dbz[d]), edbz);
    chk($sformatf("dir_overflow %0d/%0d", a, b), int'(o_ovf[d]), eovf);
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && n < 3000) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("drain_complete", sb0.size() + sb1.size(), 0);
  endtask

  initial begin
    int quiet;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset output_valid dut%0d", d), int'(o_vld[d]), 0);
      chk($sformatf("reset quotient dut%0d", d), int'(o_quo[d]), 0);
      chk($sformatf("reset remainder dut%0d", d), int'(o_rem[d]), 0);
      chk($sformatf("reset output_tag dut%0d", d), int'(o_tag[d]), 0);
      chk($sformatf("reset flags dut%0d", d), int'({o_dbz[d], o_ovf[d]}), 0);
      chk($sformatf("reset input_ready dut%0d", d), int'(o_rdy[d]), 1);
    end
    @(posedge clock);
    #1;

    // Known-answer beats.
    directed(0, -100,  7, 1'b0,  -14,  -2, 0, 0);
    directed(0, -100,  7, 1'b1,  -14,  -2, 0, 0);
    directed(0,  100,  8, 1'b1,   13,   4, 0, 0);
    directed(1, -2048, -1, 1'b0, 2047,  0, 0, 1);
    directed(1,  2047, -2, 1'b0, -1023, 1, 0, 0);
    directed(0,   -5,  0, 1'b0, -2048, -5, 1, 0);
    directed(0,    5,  0, 1'b0,  2047,  5, 1, 0);
    directed(0, -2048, 1, 1'b0, -2048,  0, 0, 0);
    directed(0,  100, 63, 1'b1,    2, 37, 0, 0);
    directed(1,  -97, -32, 1'b1,   3, -1, 0, 0);

    // Back-to-back tagged stream under random backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) rand_beat(TW'(i));
    drain();

    // Stream with bubbles.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clock);
        #1;
      end
      rand_beat(TW'(i + 40));
    end
    drain();

    // Reset with ten beats in flight: none of them may surface afterwards.
    rand_rdy     = 1'b0;
    output_ready = 1'b1;
    for (int i = 0; i < 10; i++) rand_beat(TW'(48 + i));
    reset_n = 1'b0;
    sb0.delete();
    sb1.delete();
    @(posedge clock);
    #1 reset_n = 1'b1;
    quiet = 0;
    repeat (2 * DW) begin
      @(negedge clock);
      if (o_vld[0] || o_vld[1]) quiet++;
    end
    chk("post_reset_quiet", quiet, 0);
    @(posedge clock);
    #1;
    rand_rdy = 1'b1;
    for (int i = 0; i < 8; i++) rand_beat(TW'(16 + i));
    drain();
    rand_rdy     = 1'b0;
    output_ready = 1'b1;
    repeat (DW + 4) @(posedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipelined_divider_stall.md
PIPELINED_DIVIDER_STALL -- requirements
Module: pipelined_divider_stall

Interface
REQ-001 SHALL have parameter DIVIDEND_WIDTH, default 12: dividend, quotient and remainder width.
REQ-002 SHALL have parameter DIVISOR_WIDTH, default 6: divisor width.
REQ-003 SHALL have parameter TAG_WIDTH, default 6: sideband tag width.
REQ-004 SHALL have parameter DIVISOR_SIGNED, default 0: 1 = divisor is two's complement, 0 = divisor is unsigned.
REQ-005 SHALL have ports, one per line (name, direction, width, meaning):
  clock  in  1  single clock, all state on rising edge
  reset_n  in  1  synchronous active-low reset
  input_valid  in  1  operand beat offered
  input_ready  out  1  block accepts a beat this cycle
  input_tag  in  TAG_WIDTH  sideband carried to output
  input_round  in  1  1 = round to nearest, 0 = truncate toward zero
  dividend  in  DIVIDEND_WIDTH  signed dividend
  divisor  in  DIVISOR_WIDTH  divisor, signedness per DIVISOR_SIGNED
  output_valid  out  1  result beat present
  output_ready  in  1  consumer takes result this cycle
  output_tag  out  TAG_WIDTH  tag of the result
  quotient  out  DIVIDEND_WIDTH  signed quotient
  remainder  out  DIVIDEND_WIDTH  signed remainder
  div_by_zero  out  1  divisor was zero
  overflow  out  1  true quotient not representable

Function
REQ-006 SHALL use one global advance enable: advance = !output_valid || output_ready; input_ready SHALL equal advance combinationally.
REQ-007 A beat SHALL be accepted when input_valid && input_ready; when advance is 0, every pipeline register (data, tag, valid, flags) SHALL hold.
REQ-008 SHALL have a stage-0 register, DIVIDEND_WIDTH restoring-division stages, and an output register: latency exactly DIVIDEND_WIDTH+2 advancing cycles, throughput one beat per advancing cycle.
REQ-009 Stage 0 SHALL register the magnitudes |dividend| and |divisor| (magnitude width DIVIDEND_WIDTH and DIVISOR_WIDTH, unsigned), result sign = sign(dividend) XOR sign(divisor), remainder sign = sign(dividend), input_round, tag, and the zero-divisor flag.
REQ-010 Each stage SHALL shift the combined remainder/quotient register left by one, subtract the divisor magnitude from the upper bits when no borrow results, and set the quotient LSB to 1 on a successful subtraction.
REQ-011 Magnitude quotient SHALL equal floor(|dividend|/|divisor|); the magnitude remainder SHALL equal |dividend| - q*|divisor|.
REQ-012 When round=1 and 2*rem_mag >= div_mag, the magnitude quotient SHALL be incremented by 1 (round half away from zero); the remainder SHALL NOT be adjusted.
REQ-013 Quotient SHALL be negated when the result sign is 1; remainder SHALL be negated when the dividend is negative.
REQ-014 Most-negative dividend (-2^(DIVIDEND_WIDTH-1)) SHALL be handled exactly, with no loss of its magnitude.
REQ-015 If the signed result exceeds 2^(DIVIDEND_WIDTH-1)-1, quotient SHALL saturate to 2^(DIVIDEND_WIDTH-1)-1 and overflow SHALL be 1. This includes -2048/-1 with DIVISOR_SIGNED=1.
REQ-016 Divisor = 0: div_by_zero=1, overflow=0, remainder=dividend. Quotient SHALL be 2^(DIVIDEND_WIDTH-1)-1 if dividend >= 0, else -2^(DIVIDEND_WIDTH-1).
REQ-017 output_tag, quotient, remainder and flags SHALL be stable while output_valid && !output_ready.
REQ-018 Invalid beats (bubbles) SHALL propagate as output_valid=0 and SHALL NOT be collapsed; the data of a bubble is don't-care.

Reset
REQ-019 On a rising edge with reset_n=0, all stage valid bits and output_valid SHALL clear to 0, and div_by_zero and overflow SHALL clear to 0. Quotient, remainder and output_tag SHALL clear to 0.
REQ-020 input_ready SHALL be 1 in the first cycle after reset is released.
REQ-021 Reset asserted mid-operation SHALL discard all in-flight beats; no beat accepted before reset SHALL emerge afterwards.
REQ-022 Data registers other than outputs need not be reset.

Verification
REQ-023 Defaults, output_ready=1, one beat -100/7 with round=0 -> after 14 cycles: quotient=-14, remainder=-2, flags 0.
REQ-024 Same beat with round=1 -> quotient=-14 (2*2<7). The beat 100/8 with round=1 -> quotient=13 (12.5 rounded away from zero), remainder=4.
REQ-025 DIVISOR_SIGNED=1: -2048/-1 -> quotient=2047, overflow=1. The beat 2047/-2 with round=0 -> quotient=-1023, remainder=1.
REQ-026 Divisor 0 with dividend -5 -> quotient=-2048, remainder=-5, div_by_zero=1. Dividend 5 -> quotient=2047.
REQ-027 Stream 40 back-to-back tagged beats while output_ready toggles randomly. Each output SHALL match a golden model, tags SHALL emerge in order with none lost or duplicated, and input_ready SHALL track REQ-006.
REQ-028 Assert reset_n=0 for one cycle with 10 beats in flight -> output_valid=0 until new beats traverse the pipeline. No stale tag SHALL appear.
